// File: rtl/line_raster_pkg.sv
// Shared types, default parameters and the pixel offset helper for the line rasteriser.
package line_raster_pkg;

    localparam int DEF_COORD_W         = 16;
    localparam int DEF_COLOR_W         = 16;
    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_FB_STRIDE       = 640;
    localparam int DEF_FB_WIDTH        = 640;
    localparam int DEF_FB_HEIGHT       = 480;
    localparam int DEF_BYTES_PER_PIXEL = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } line_state_e;

    typedef struct packed {
        line_state_e state;
        logic        on_screen;
    } line_dbg_t;

    // Signed byte offset of (x,y); callers truncate to their address width so off-screen pixels wrap.
    function automatic longint pixel_offset(input longint x, input longint y,
                                            input longint stride, input longint bpp);
        return (y * stride + x) * bpp;
    endfunction

endpackage

// File: rtl/line_raster_if.sv
// Command and pixel-write handshakes of the line rasteriser, bundled for port connection.
interface line_raster_if #(
    parameter int COORD_W = 16,
    parameter int COLOR_W = 16,
    parameter int ADDR_W  = 32
);
    // Both channels: a transfer occurs on a rising clk edge with valid && ready; the sender keeps
    // valid high and the payload stable until then, and never makes valid depend on ready.
    logic [ADDR_W-1:0]         fb_base;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic signed [COORD_W-1:0] cmd_x0;
    logic signed [COORD_W-1:0] cmd_y0;
    logic signed [COORD_W-1:0] cmd_x1;
    logic signed [COORD_W-1:0] cmd_y1;
    logic [COLOR_W-1:0]        cmd_color;
    logic                      px_valid;
    logic                      px_ready;
    logic [ADDR_W-1:0]         px_addr;
    logic [COLOR_W-1:0]        px_data;

    modport slave (
        input  fb_base, cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, px_ready,
        output cmd_ready, px_valid, px_addr, px_data
    );

    modport master (
        output fb_base, cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, px_ready,
        input  cmd_ready, px_valid, px_addr, px_data
    );
endinterface

// File: rtl/line_raster_addr.sv
// Registered pixel address: base + offset(x,y), loaded together with the pixel coordinate.
module line_raster_addr
    import line_raster_pkg::*;
#(
    parameter int COORD_W         = DEF_COORD_W,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int FB_STRIDE       = DEF_FB_STRIDE,
    parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      load,
    input  logic [ADDR_W-1:0]         base,
    input  logic signed [COORD_W-1:0] x,
    input  logic signed [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]         addr
);
    logic [63:0] off;
    logic        unused_off_hi;

    always_comb begin
        off = 64'(pixel_offset(longint'(x), longint'(y),
                               longint'(FB_STRIDE), longint'(BYTES_PER_PIXEL)));
    end

    // Bits above ADDR_W are discarded on purpose: addresses wrap.
    assign unused_off_hi = ^off[63:ADDR_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr <= '0;
        end else if (load) begin
            addr <= base + off[ADDR_W-1:0];
        end
    end
endmodule

// File: rtl/line_raster_engine.sv
// All-octant Bresenham line rasteriser emitting one framebuffer write request per pixel.
// Define LINE_RASTER_CLIP_EN to step through off-screen pixels without emitting them.
module line_raster_engine
    import line_raster_pkg::*;
#(
    parameter int COORD_W         = DEF_COORD_W,
    parameter int COLOR_W         = DEF_COLOR_W,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int FB_STRIDE       = DEF_FB_STRIDE,
    parameter int FB_WIDTH        = DEF_FB_WIDTH,
    parameter int FB_HEIGHT       = DEF_FB_HEIGHT,
    parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL
) (
    input  logic             clk,
    input  logic             resetn,
    line_raster_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic [COORD_W:0] px_count,
    output line_dbg_t        dbg
);
    localparam int EW = COORD_W + 2;
    localparam logic signed [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic [COORD_W:0] CNT_ONE = {{COORD_W{1'b0}}, 1'b1};

    line_state_e               state, state_nx;
    logic signed [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q, cur_x, cur_y;
    logic [COLOR_W-1:0]        color_q;
    logic [ADDR_W-1:0]         base_q;
    logic signed [EW-1:0]      dx_q, dy_q, err_q;
    logic                      sx_neg_q, sy_neg_q;

    logic signed [EW-1:0]      diff_x, diff_y, abs_dx, nabs_dy, err_nx;
    logic signed [EW:0]        e2, dx_w, dy_w;
    logic signed [COORD_W-1:0] x_nx, y_nx, load_x, load_y;
    logic                      step_x, step_y, at_end, on_screen, emit, fire, advance, addr_load;

    assign diff_x  = EW'(x1_q) - EW'(x0_q);
    assign diff_y  = EW'(y1_q) - EW'(y0_q);
    assign abs_dx  = diff_x[EW-1] ? -diff_x : diff_x;
    assign nabs_dy = diff_y[EW-1] ? diff_y : -diff_y;

    // e2 carries one extra bit so 2*err cannot overflow; both tests use the pre-step err.
    assign e2      = {err_q, 1'b0};
    assign dx_w    = {dx_q[EW-1], dx_q};
    assign dy_w    = {dy_q[EW-1], dy_q};
    assign step_x  = (e2 >= dy_w);
    assign step_y  = (e2 <= dx_w);
    assign err_nx  = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    assign x_nx    = step_x ? (sx_neg_q ? cur_x - ONE : cur_x + ONE) : cur_x;
    assign y_nx    = step_y ? (sy_neg_q ? cur_y - ONE : cur_y + ONE) : cur_y;
    assign at_end  = (cur_x == x1_q) && (cur_y == y1_q);

    assign on_screen = (longint'(cur_x) >= 64'sd0) && (longint'(cur_x) < longint'(FB_WIDTH)) &&
                       (longint'(cur_y) >= 64'sd0) && (longint'(cur_y) < longint'(FB_HEIGHT));
`ifdef LINE_RASTER_CLIP_EN
    assign emit = on_screen;
`else
    assign emit = 1'b1;
`endif

    assign fire    = bus.px_valid && bus.px_ready;
    // Off-screen pixels advance without a handshake, one cycle each.
    assign advance = (state == DRAW) && (fire || !emit);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.px_valid  = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (bus.cmd_valid) state_nx = SETUP;
            end
            SETUP: state_nx = DRAW;
            DRAW: begin
                bus.px_valid = emit;
                if (advance && at_end) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            base_q   <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            cur_x    <= '0;
            cur_y    <= '0;
            px_count <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    x0_q    <= bus.cmd_x0;
                    y0_q    <= bus.cmd_y0;
                    x1_q    <= bus.cmd_x1;
                    y1_q    <= bus.cmd_y1;
                    color_q <= bus.cmd_color;
                    base_q  <= bus.fb_base;
                end
                SETUP: begin
                    dx_q     <= abs_dx;
                    dy_q     <= nabs_dy;
                    err_q    <= abs_dx + nabs_dy;
                    sx_neg_q <= !(x0_q < x1_q);
                    sy_neg_q <= !(y0_q < y1_q);
                    cur_x    <= x0_q;
                    cur_y    <= y0_q;
                    px_count <= '0;
                end
                DRAW: begin
                    if (fire) px_count <= px_count + CNT_ONE;
                    if (advance && !at_end) begin
                        err_q <= err_nx;
                        cur_x <= x_nx;
                        cur_y <= y_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // The address register loads alongside cur, so it is ready in the same cycle as px_valid.
    assign addr_load = (state == SETUP) || (advance && !at_end);
    assign load_x    = (state == SETUP) ? x0_q : x_nx;
    assign load_y    = (state == SETUP) ? y0_q : y_nx;

    line_raster_addr #(
        .COORD_W         (COORD_W),
        .ADDR_W          (ADDR_W),
        .FB_STRIDE       (FB_STRIDE),
        .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
    ) u_addr (
        .clk    (clk),
        .resetn (resetn),
        .load   (addr_load),
        .base   (base_q),
        .x      (load_x),
        .y      (load_y),
        .addr   (bus.px_addr)
    );

    assign bus.px_data   = color_q;
    assign dbg.state     = state;
    assign dbg.on_screen = on_screen;
endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine: a pixel-list model feeds an expected queue checked every cycle.
module tb_line_raster_engine;
    import line_raster_pkg::*;

    localparam int CW = 16;
    localparam int KW = 16;
    localparam int AW = 32;

    logic      clk = 1'b0;
    logic      resetn = 1'b0;
    logic      busy, done;
    logic [CW:0] px_count;
    line_dbg_t dbg;

    line_raster_if #(.COORD_W(CW), .COLOR_W(KW), .ADDR_W(AW)) bus ();

    line_raster_engine #(
        .COORD_W(CW), .COLOR_W(KW), .ADDR_W(AW),
        .FB_STRIDE(640), .FB_WIDTH(640), .FB_HEIGHT(480), .BYTES_PER_PIXEL(2)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .px_count (px_count),
        .dbg      (dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [AW+KW-1:0] exp_q[$];
    logic [AW-1:0]    seen_q[$];
    logic [AW+KW-1:0] exp_item;
    logic             stall_prev = 1'b0;
    logic [AW-1:0]    addr_prev = '0;
    logic [KW-1:0]    data_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic bit visible(input int x, input int y);
`ifdef LINE_RASTER_CLIP_EN
        return (x >= 0) && (x < 640) && (y >= 0) && (y < 480);
`else
        return 1'b1;
`endif
    endfunction

    // Reference pixel list: plain integer Bresenham from (x0,y0) to (x1,y1), inclusive.
    task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                              input logic [KW-1:0] color, input logic [AW-1:0] base, output int n);
        int dx, dy, sx, sy, err, e2, x, y;
        longint off;
        logic [AW-1:0] a;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        n   = 0;
        for (int guard = 0; guard < 70000; guard++) begin
            if (visible(x, y)) begin
                off = (longint'(y) * 640 + longint'(x)) * 2;
                a   = base + off[AW-1:0];
                exp_q.push_back({a, color});
                n++;
            end
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Compare process: every handshake against the model queue, every stall for stable payload.
    always @(negedge clk) begin
        if (resetn) begin
            if (stall_prev) begin
                check("stall_valid", 64'(bus.px_valid), 64'd1);
                check("stall_addr", 64'(bus.px_addr), 64'(addr_prev));
                check("stall_data", 64'(bus.px_data), 64'(data_prev));
            end
            if (bus.px_valid && bus.px_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_pixel: got addr 0x%0h, required no pixel", bus.px_addr);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("pixel", 64'({bus.px_addr, bus.px_data}), 64'(exp_item));
                end
                seen_q.push_back(bus.px_addr);
            end
            stall_prev = bus.px_valid && !bus.px_ready;
            addr_prev  = bus.px_addr;
            data_prev  = bus.px_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [KW-1:0] color, input logic [AW-1:0] base);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_x0    = 16'(x0);
        bus.cmd_y0    = 16'(y0);
        bus.cmd_x1    = 16'(x1);
        bus.cmd_y1    = 16'(y1);
        bus.cmd_color = color;
        bus.fb_base   = base;
        @(negedge clk);
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        // Garbage on the command bus while busy must not disturb the line.
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = 16'sh7fff;
        bus.cmd_y0    = -16'sd5;
        bus.cmd_x1    = 16'sd123;
        bus.cmd_y1    = 16'sh7ff0;
        bus.cmd_color = ~color;
        bus.fb_base   = ~base;
    endtask

    // mode 0: px_ready held high; mode 1: px_ready 1,0,1,0... starting on the first pixel cycle.
    // done_cyc counts cycles after the accept edge (SETUP is cycle 1).
    task automatic draw_line(input int x0, input int y0, input int x1, input int y1,
                             input logic [KW-1:0] color, input logic [AW-1:0] base,
                             input int mode, output int done_cyc, output int n);
        model_line(x0, y0, x1, y1, color, base, n);
        seen_q.delete();
        send_cmd(x0, y0, x1, y1, color, base);
        done_cyc = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            bus.px_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            @(negedge clk);
            if (cyc == 1) check("setup_busy_ready", 64'({busy, bus.cmd_ready}), 64'b10);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done in 400 cycles, required one");
        end else begin
            check("px_count_at_done", 64'(px_count), 64'(n));
            check("all_pixels_seen", 64'(exp_q.size()), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("after_done", 64'({busy, bus.cmd_ready, done}), 64'b010);
        end
    endtask

    // ---------------- stimulus ----------------
    int dc, n, v;
    int xp;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.px_ready  = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y1    = '0;
        bus.cmd_color = '0;
        bus.fb_base   = '0;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_px_valid", 64'(bus.px_valid), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_px_count", 64'(px_count), 64'd0);
        check("rst_px_addr", 64'(bus.px_addr), 64'd0);
        check("rst_px_data", 64'(bus.px_data), 64'd0);
        check("rst_state", 64'(dbg.state), 64'(IDLE));
        @(posedge clk); #1;
        resetn = 1'b1;

        // Horizontal: 6 pixels; done lands in cycle P+2 after the accept edge (P+3 counting accept).
        draw_line(0, 0, 5, 0, 16'hABCD, 32'h1000, 0, dc, n);
        check("h_done_cycle", 64'(dc), 64'd8);
        check("h_count", 64'(px_count), 64'd6);
        check("h_seen", 64'(seen_q.size()), 64'd6);
        for (int i = 0; i < seen_q.size() && i < 6; i++)
            check("h_addr", 64'(seen_q[i]), 64'(32'h1000 + 32'(2 * i)));

        // Steep reversed: y runs 7..0, x never increases, ends at (1,0).
        draw_line(3, 7, 1, 0, 16'h1234, 32'h0, 0, dc, n);
        check("steep_count", 64'(px_count), 64'd8);
        check("steep_done_cycle", 64'(dc), 64'd10);
        check("steep_seen", 64'(seen_q.size()), 64'd8);
        if (seen_q.size() == 8) begin
            check("steep_first", 64'(seen_q[0]), 64'd8966);
            check("steep_last", 64'(seen_q[7]), 64'd2);
            xp = 3;
            for (int i = 0; i < 8; i++) begin
                v = int'(seen_q[i] >> 1);
                check("steep_y", 64'(v / 640), 64'(7 - i));
                check("steep_x_mono", 64'((v % 640) <= xp), 64'd1);
                xp = v % 640;
            end
        end

        // Degenerate: exactly one pixel at base + (4*640+4)*2.
        draw_line(4, 4, 4, 4, 16'h00FF, 32'h1000, 0, dc, n);
        check("degen_count", 64'(px_count), 64'd1);
        check("degen_done_cycle", 64'(dc), 64'd3);
        check("degen_seen", 64'(seen_q.size()), 64'd1);
        if (seen_q.size() == 1) check("degen_addr", 64'(seen_q[0]), 64'h2408);

        // Diagonal under alternating backpressure: handshakes in cycles 2,4,6,8.
        draw_line(0, 0, 3, 3, 16'h5A5A, 32'h2000, 1, dc, n);
        check("bp_count", 64'(px_count), 64'd4);
        check("bp_done_cycle", 64'(dc), 64'd9);
        check("bp_seen", 64'(seen_q.size()), 64'd4);
        if (seen_q.size() == 4) begin
            check("bp_addr0", 64'(seen_q[0]), 64'h2000);
            check("bp_addr1", 64'(seen_q[1]), 64'h2502);
            check("bp_addr2", 64'(seen_q[2]), 64'h2A04);
            check("bp_addr3", 64'(seen_q[3]), 64'h2F06);
        end

        // Other octants, checked against the model only.
        draw_line(5, 2, 0, 4, 16'h0F0F, 32'h4000, 0, dc, n);
        check("oct_a_count", 64'(px_count), 64'd6);
        draw_line(1, 1, 2, 6, 16'hF0F0, 32'h6000, 1, dc, n);
        check("oct_b_count", 64'(px_count), 64'd6);

        // Reset in DRAW after two pixels.
        model_line(0, 0, 10, 0, 16'h7777, 32'h0, n);
        seen_q.delete();
        send_cmd(0, 0, 10, 0, 16'h7777, 32'h0);
        bus.px_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && seen_q.size() < 2; cyc++) @(negedge clk);
        check("rst_mid_two_pixels", 64'(seen_q.size()), 64'd2);
        @(posedge clk); #1;
        resetn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_no_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_mid_px_valid", 64'(bus.px_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_mid_px_count", 64'(px_count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_done_quiet", 64'(done), 64'd0);
        end

        draw_line(2, 3, 6, 5, 16'hC0DE, 32'h8000, 0, dc, n);
        check("post_rst_count", 64'(px_count), 64'd5);
        check("post_rst_done_cycle", 64'(dc), 64'd7);

        // Line crossing x=0: every one of the 5 positions costs one cycle either way.
        draw_line(-2, 0, 2, 0, 16'hF00D, 32'h100, 0, dc, n);
        check("clip_done_cycle", 64'(dc), 64'd7);
`ifdef LINE_RASTER_CLIP_EN
        check("clip_count", 64'(px_count), 64'd3);
        if (seen_q.size() > 0) check("clip_first_addr", 64'(seen_q[0]), 64'h100);
`else
        check("clip_count", 64'(px_count), 64'd5);
        if (seen_q.size() > 0) check("clip_first_addr", 64'(seen_q[0]), 64'hFC);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL global_timeout: got no end of test by 200000, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
